// File: rtl/regfile8_if.sv
// Register-file access bus: one write port and two registered read ports.
interface regfile8_if #(
  parameter int unsigned WIDTH = 32
);
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en_a;
  logic [2:0]       rd_addr_a;
  logic [WIDTH-1:0] rd_data_a;
  logic             rd_en_b;
  logic [2:0]       rd_addr_b;
  logic [WIDTH-1:0] rd_data_b;

  // Requester side: drives writes and read addresses, receives read data.
  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en_a, rd_addr_a,
    output rd_en_b, rd_addr_b,
    input  rd_data_a, rd_data_b
  );

  // Register-file side.
  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en_a, rd_addr_a,
    input  rd_en_b, rd_addr_b,
    output rd_data_a, rd_data_b
  );
endinterface

// File: rtl/regfile8.sv
// 8-entry register file, R7 hardwired to zero, one write port and two
// independent registered read ports with write-to-read bypass.
module regfile8 #(
  parameter int unsigned WIDTH = 32,
  parameter real         DELAY = 0.05
) (
  input logic        clk,
  input logic        reset_n,
  regfile8_if.slave  bus
);

  localparam int unsigned NREGS    = 8;
  localparam int unsigned NWRITE   = 7;
  localparam logic [2:0]  ZERO_IDX = 3'd7;

  // Gate delay only has meaning for structural netlists; reject nonsense values.
  if (DELAY < 0.0) begin : g_bad_delay
    $error("regfile8: DELAY must be non-negative");
  end

  logic [NREGS-1:0] w_wr_sel;
  logic [WIDTH-1:0] w_view [NREGS];
  logic             w_byp_a;
  logic             w_byp_b;
  logic [WIDTH-1:0] r_rd_a;
  logic [WIDTH-1:0] r_rd_b;

  // One-hot write select; bit 7 forced low so R7 can never be written or bypassed.
  always_comb begin
    w_wr_sel = '0;
    if (bus.wr_en) begin
      w_wr_sel = NREGS'(1) << bus.wr_addr;
    end
    w_wr_sel[ZERO_IDX] = 1'b0;
  end

  // Storage for R0..R6; each register loads only when its select bit is set.
  for (genvar g = 0; g < NWRITE; g++) begin : g_reg
    logic [WIDTH-1:0] r_q;

    // Per-register storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_q <= '0;
      end else if (w_wr_sel[g]) begin
        r_q <= bus.wr_data;
      end
    end

    assign w_view[g] = r_q;
  end

  assign w_view[ZERO_IDX] = '0;

  // Same-edge write to the addressed register wins over the stored value.
  assign w_byp_a = w_wr_sel[bus.rd_addr_a];
  assign w_byp_b = w_wr_sel[bus.rd_addr_b];

  // Read port A capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_a <= '0;
    end else if (bus.rd_en_a) begin
      r_rd_a <= w_byp_a ? bus.wr_data : w_view[bus.rd_addr_a];
    end
  end

  // Read port B capture register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_b <= '0;
    end else if (bus.rd_en_b) begin
      r_rd_b <= w_byp_b ? bus.wr_data : w_view[bus.rd_addr_b];
    end
  end

  assign bus.rd_data_a = r_rd_a;
  assign bus.rd_data_b = r_rd_b;

endmodule

// File: tb/tb_regfile8.sv
// Self-checking bench for regfile8 using a reference model and result queues.
module tb_regfile8;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic reset_n;

  regfile8_if #(.WIDTH(WIDTH)) bus ();

  regfile8 #(.WIDTH(WIDTH), .DELAY(0.05)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model [8];
  logic [WIDTH-1:0] cur_a, cur_b;
  logic [WIDTH-1:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];
  logic [WIDTH-1:0] ea, eb, oa, ob;

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 3'd0;
    bus.wr_data   = '0;
    bus.rd_en_a   = 1'b0;
    bus.rd_addr_a = 3'd0;
    bus.rd_en_b   = 1'b0;
    bus.rd_addr_b = 3'd0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = '0;
    cur_a = '0;
    cur_b = '0;
  endtask

  // Drive one cycle, push the model's expected outputs, then record what the DUT shows.
  task automatic do_cycle(input logic we, input logic [2:0] wa, input logic [WIDTH-1:0] wd,
                          input logic rea, input logic [2:0] raa,
                          input logic reb, input logic [2:0] rab);
    bus.wr_en = we;  bus.wr_addr = wa;  bus.wr_data = wd;
    bus.rd_en_a = rea; bus.rd_addr_a = raa;
    bus.rd_en_b = reb; bus.rd_addr_b = rab;
    if (rea) cur_a = (raa == 3'd7) ? '0 : ((we && wa == raa) ? wd : model[raa]);
    if (reb) cur_b = (rab == 3'd7) ? '0 : ((we && wa == rab) ? wd : model[rab]);
    exp_a.push_back(cur_a);
    exp_b.push_back(cur_b);
    if (we && wa != 3'd7) model[wa] = wd;
    @(posedge clk);
    @(negedge clk);
    obs_a.push_back(bus.rd_data_a);
    obs_b.push_back(bus.rd_data_b);
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rd_data_a !== '0) begin
      errors++; $display("FAIL reset rd_data_a: got %h expected 0", bus.rd_data_a);
    end
    checks++;
    if (bus.rd_data_b !== '0) begin
      errors++; $display("FAIL reset rd_data_b: got %h expected 0", bus.rd_data_b);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) do_cycle(1'b0, 3'd0, '0, 1'b1, 3'(i), 1'b1, 3'(6 - i));
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL reset_read A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL reset_read B: got %h expected %h", ob, eb); end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 7; i++)
      do_cycle(1'b1, 3'(i), WIDTH'(32'h1111_1111 * (i + 1)), 1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 7; i++) do_cycle(1'b0, 3'd0, '0, 1'b1, 3'(i), 1'b1, 3'(6 - i));
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL write_read A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL write_read B: got %h expected %h", ob, eb); end
    end
  endtask

  task automatic test_r7();
    do_cycle(1'b1, 3'd7, 32'hDEAD_BEEF, 1'b1, 3'd7, 1'b1, 3'd7);
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd7, 1'b1, 3'd7);
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd0, 1'b1, 3'd6);
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL r7_zero A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL r7_zero B: got %h expected %h", ob, eb); end
    end
  endtask

  task automatic test_bypass();
    do_cycle(1'b1, 3'd3, 32'h5, 1'b0, 3'd0, 1'b0, 3'd0);
    do_cycle(1'b1, 3'd3, 32'hA, 1'b1, 3'd3, 1'b1, 3'd3);
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd3, 1'b1, 3'd3);
    do_cycle(1'b1, 3'd5, 32'h1234_5678, 1'b1, 3'd5, 1'b1, 3'd4);
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL bypass A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL bypass B: got %h expected %h", ob, eb); end
    end
  endtask

  task automatic test_rd_hold();
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd2, 1'b1, 3'd4);
    // Address changes alone must not move the registered output.
    bus.rd_addr_a = 3'd1;
    bus.rd_addr_b = 3'd6;
    #1;
    checks++;
    if (bus.rd_data_a !== cur_a) begin
      errors++; $display("FAIL comb_addr A: got %h expected %h", bus.rd_data_a, cur_a);
    end
    do_cycle(1'b0, 3'd0, '0, 1'b0, 3'd0, 1'b0, 3'd1);
    do_cycle(1'b0, 3'd0, '0, 1'b0, 3'd5, 1'b0, 3'd7);
    do_cycle(1'b1, 3'd6, 32'hCAFE_0006, 1'b0, 3'd6, 1'b0, 3'd6);
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd6, 1'b1, 3'd1);
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL rd_hold A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL rd_hold B: got %h expected %h", ob, eb); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 3'(i), WIDTH'($urandom) | 32'h1, 1'b0, 3'd0, 1'b0, 3'd0);
    do_cycle(1'b0, 3'd0, '0, 1'b1, 3'd1, 1'b1, 3'd5);
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL preload A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL preload B: got %h expected %h", ob, eb); end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_data_a !== '0) begin errors++; $display("FAIL async_clr A: got %h expected 0", bus.rd_data_a); end
    checks++;
    if (bus.rd_data_b !== '0) begin errors++; $display("FAIL async_clr B: got %h expected 0", bus.rd_data_b); end
    // Writes and reads during reset are ignored.
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 32'hFFFF_FFFF;
    bus.rd_en_a = 1'b1; bus.rd_addr_a = 3'd2; bus.rd_en_b = 1'b1; bus.rd_addr_b = 3'd2;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.rd_data_a !== '0) begin errors++; $display("FAIL in_reset A: got %h expected 0", bus.rd_data_a); end
    checks++;
    if (bus.rd_data_b !== '0) begin errors++; $display("FAIL in_reset B: got %h expected 0", bus.rd_data_b); end
    idle();
    model_clear();
    reset_n = 1'b1;
    do_cycle(1'b1, 3'd4, 32'h00C0_FFEE, 1'b1, 3'd4, 1'b1, 3'd2);
    for (int i = 0; i < 7; i++) do_cycle(1'b0, 3'd0, '0, 1'b1, 3'(i), 1'b1, 3'(6 - i));
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL post_reset A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL post_reset B: got %h expected %h", ob, eb); end
    end
  endtask

  task automatic test_no_write();
    for (int i = 0; i < 7; i++)
      do_cycle(1'b1, 3'(i), WIDTH'(32'hA5A5_0000 + i), 1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++)
      do_cycle(1'b0, 3'(i), WIDTH'($urandom), 1'b1, 3'(i), 1'b1, 3'(7 - i));
    for (int i = 0; i < 7; i++) do_cycle(1'b0, 3'd0, '0, 1'b1, 3'(i), 1'b1, 3'(i));
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL no_write A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL no_write B: got %h expected %h", ob, eb); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++)
      do_cycle(1'($urandom), 3'($urandom_range(0, 7)), WIDTH'($urandom),
               1'($urandom), 3'($urandom_range(0, 7)),
               1'($urandom), 3'($urandom_range(0, 7)));
    while (exp_a.size() > 0) begin
      ea = exp_a.pop_front(); eb = exp_b.pop_front(); oa = obs_a.pop_front(); ob = obs_b.pop_front();
      checks++;
      if (oa !== ea) begin errors++; $display("FAIL random A: got %h expected %h", oa, ea); end
      checks++;
      if (ob !== eb) begin errors++; $display("FAIL random B: got %h expected %h", ob, eb); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_r7();
    test_bypass();
    test_rd_hold();
    test_async_reset();
    test_no_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/regfile8.md
REGFILE8 -- requirements
Module: regfile8

Interface
REQ-001: Parameter WIDTH, default 32, data width of every register and data port.
REQ-002: Parameter DELAY, default 0.05, gate delay in ns applied to structural primitives.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: reset_n  input  1  reset, asynchronous and active-low.
REQ-005: wr_en  input  1  write enable for the write port.
REQ-006: wr_addr  input  3  write register index 0..7.
REQ-007: wr_data  input  WIDTH  write data.
REQ-008: rd_en_a  input  1  read-port A capture enable.
REQ-009: rd_addr_a  input  3  read-port A register index.
REQ-010: rd_data_a  output  WIDTH  registered read-port A data.
REQ-011: rd_en_b  input  1  read-port B capture enable.
REQ-012: rd_addr_b  input  3  read-port B register index.
REQ-013: rd_data_b  output  WIDTH  registered read-port B data.

Function
REQ-014: The block SHALL hold eight WIDTH-bit registers R0..R7.
REQ-015: Write-select SHALL be a one-hot 8-bit vector from a 3-to-8 decode of wr_addr gated by wr_en; at most one bit set.
REQ-016: On a rising clk edge with wr_en=1 and wr_addr in 0..6, R[wr_addr] SHALL load wr_data; all other registers hold.
REQ-017: R7 SHALL be a hardwired zero register: writes to index 7 are discarded, and reads of index 7 return 0.
REQ-018: With wr_en=0, no register SHALL change.
REQ-019: Read latency SHALL be exactly one cycle: on a rising edge with rd_en_x=1, rd_data_x loads the value of R[rd_addr_x].
REQ-020: With rd_en_x=0, rd_data_x SHALL hold its previous value.
REQ-021: Bypass: if on the same edge rd_en_x=1, wr_en=1 and rd_addr_x==wr_addr (index not 7), rd_data_x SHALL load wr_data, not the old register value.
REQ-022: Ports A and B SHALL be independent; both may address the same register, and both see the bypass on the same edge.
REQ-023: Bypass SHALL never apply to index 7; a read of 7 always yields 0, even with a simultaneous write to 7.
REQ-024: rd_data_a and rd_data_b SHALL change only on a rising clk edge or on reset assertion; they never change combinationally with address inputs.

Reset
REQ-025: On reset_n falling to 0, R0..R6, rd_data_a and rd_data_b SHALL clear to 0 immediately, independent of clk.
REQ-026: While reset_n=0, clk edges SHALL have no effect; writes and reads are ignored.
REQ-027: A write coinciding with reset assertion SHALL be lost; the register reads 0 afterwards.
REQ-028: The first rising edge after reset_n returns to 1 SHALL operate normally.

Verification
REQ-029: Reset, then write R0..R6 with 0x11111111*(i+1), then read each on port A with one-cycle latency -> rd_data_a equals the written value one edge after the address is presented.
REQ-030: Write 0xDEADBEEF to index 7, then read 7 on both ports -> rd_data_a = rd_data_b = 0.
REQ-031: R3 holds 0x5; same edge: wr_en=1, wr_addr=3, wr_data=0xA, rd_addr_a=3, rd_addr_b=3 -> both rd_data = 0xA after that edge; the next read of R3 also gives 0xA.
REQ-032: rd_en_a=0 with rd_addr_a changing for 3 cycles -> rd_data_a unchanged; then rd_en_a=1 -> rd_data_a updates after one edge.
REQ-033: Assert reset_n=0 mid-cycle, between edges, after registers are loaded -> rd_data_a/b = 0 immediately; after release, reads of R0..R6 all return 0.
REQ-034: Sweep wr_addr 0..7 with wr_en=0 -> no register changes; this also checks that the one-hot select stays all-zero.
